// File: rtl/pc_seq_pkg.sv
// Shared encodings for the 6502 program-counter sequencer: command codes,
// sequencer states and default interrupt/reset vector addresses.
package pc_seq_pkg;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_INC    = 3'd1;
    localparam logic [2:0] CMD_BRANCH = 3'd2;
    localparam logic [2:0] CMD_JMP    = 3'd3;
    localparam logic [2:0] CMD_PUSH   = 3'd4;
    localparam logic [2:0] CMD_VEC    = 3'd5;

    localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;
    localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BR_FIX,
        ST_JMP_HI,
        ST_PUSH_L,
        ST_VEC_LO,
        ST_VEC_HI
    } pc_state_t;

endpackage

// File: rtl/pc_half_adder.sv
// 8-bit adder with carry-in and carry-out, shared by PC increment, branch
// low-byte arithmetic and the page-fix high-byte adjust.
module pc_half_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/pc_sequencer.sv
// 6502 program-counter sequencer: owns PC, sequences INC/BRANCH/JMP/PUSH/VEC
// and fetches the reset vector after RES. Define PC_BRANCH_PAGEFIX_EN for the
// NMOS extra cycle on page-crossing branches.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
    parameter logic [15:0] NMI_VECTOR   = DEF_NMI_VECTOR
) (
    input  logic        PHI0,
    input  logic        RES,
    input  logic        n_ready,
    input  logic [2:0]  cmd,
    input  logic        vec_sel,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  DL,
    output logic [15:0] PC,
    output logic [15:0] ADDR,
    output logic [7:0]  DB,
    output logic        PCH_DB,
    output logic        PCL_DB,
    output logic        PCL_ADL,
    output logic        PCH_ADH,
    output logic        busy
);

    pc_state_t   state;
    logic [15:0] pc;
    logic [15:0] vec_base;
    logic [7:0]  temp_lo;
    logic        accept;
    logic        push_accept;
    logic        vec_phase;

    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

`ifdef PC_BRANCH_PAGEFIX_EN
    logic        br_dn;
`endif

    pc_half_adder u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder defaults to PCL+1 (INC); BRANCH adds DL; BR_FIX adjusts PCH by +/-1.
    always_comb begin
        add_a   = pc[7:0];
        add_b   = '0;
        add_cin = 1'b1;
        if (cmd == CMD_BRANCH) begin
            add_b   = DL;
            add_cin = 1'b0;
        end
`ifdef PC_BRANCH_PAGEFIX_EN
        if (state == ST_BR_FIX) begin
            add_a   = pc[15:8];
            add_b   = {8{br_dn}};
            add_cin = ~br_dn;
        end
`endif
    end

    always_ff @(posedge PHI0) begin
        if (RES) begin
            state    <= ST_VEC_LO;
            pc       <= '0;
            temp_lo  <= '0;
            vec_base <= RESET_VECTOR;
`ifdef PC_BRANCH_PAGEFIX_EN
            br_dn    <= 1'b0;
`endif
        end else if (!n_ready) begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_INC:
                                pc <= {pc[15:8] + {7'b0, add_cout}, add_sum};
                            CMD_BRANCH: begin
`ifdef PC_BRANCH_PAGEFIX_EN
                                pc[7:0] <= add_sum;
                                // Carry disagreeing with the offset sign means PCH must move.
                                if (add_cout ^ DL[7]) begin
                                    br_dn <= DL[7];
                                    state <= ST_BR_FIX;
                                end
`else
                                pc <= {pc[15:8] + {8{DL[7]}} + {7'b0, add_cout}, add_sum};
`endif
                            end
                            CMD_JMP: begin
                                temp_lo <= DL;
                                state   <= ST_JMP_HI;
                            end
                            CMD_PUSH:
                                state <= ST_PUSH_L;
                            CMD_VEC: begin
                                vec_base <= vec_sel ? NMI_VECTOR : IRQ_VECTOR;
                                state    <= ST_VEC_LO;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BR_FIX: begin
`ifdef PC_BRANCH_PAGEFIX_EN
                    pc[15:8] <= add_sum;
`endif
                    state <= ST_IDLE;
                end
                ST_JMP_HI: begin
                    pc    <= {DL, temp_lo};
                    state <= ST_IDLE;
                end
                ST_PUSH_L:
                    state <= ST_IDLE;
                ST_VEC_LO: begin
                    temp_lo <= DL;
                    state   <= ST_VEC_HI;
                end
                ST_VEC_HI: begin
                    pc    <= {DL, temp_lo};
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state == ST_IDLE) & ~n_ready & ~RES;
    assign accept      = cmd_valid & cmd_ready;
    assign push_accept = accept & (cmd == CMD_PUSH);
    assign vec_phase   = (state == ST_VEC_LO) | (state == ST_VEC_HI);

    assign PC      = pc;
    assign busy    = (state != ST_IDLE);
    assign PCL_ADL = ~vec_phase;
    assign PCH_ADH = ~vec_phase;
    assign ADDR    = (state == ST_VEC_LO) ? vec_base :
                     (state == ST_VEC_HI) ? vec_base + 16'd1 : pc;
    assign PCH_DB  = push_accept;
    assign PCL_DB  = (state == ST_PUSH_L);
    assign DB      = push_accept ? pc[15:8] :
                     (state == ST_PUSH_L) ? pc[7:0] : 8'h00;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_pc_sequencer;

    localparam int OP_INC = 1, OP_BRANCH = 2, OP_JMP = 3, OP_PUSH = 4, OP_VEC = 5;

    logic        PHI0 = 1'b0;
    logic        RES;
    logic        n_ready;
    logic [2:0]  cmd;
    logic        vec_sel;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  DL;
    logic [15:0] PC;
    logic [15:0] ADDR;
    logic [7:0]  DB;
    logic        PCH_DB, PCL_DB, PCL_ADL, PCH_ADH, busy;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .RESET_VECTOR (16'hFFFC),
        .IRQ_VECTOR   (16'hFFFE),
        .NMI_VECTOR   (16'hFFFA)
    ) dut (
        .PHI0      (PHI0),
        .RES       (RES),
        .n_ready   (n_ready),
        .cmd       (cmd),
        .vec_sel   (vec_sel),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .DL        (DL),
        .PC        (PC),
        .ADDR      (ADDR),
        .DB        (DB),
        .PCH_DB    (PCH_DB),
        .PCL_DB    (PCL_DB),
        .PCL_ADL   (PCL_ADL),
        .PCH_ADH   (PCH_ADH),
        .busy      (busy)
    );

    always #5 PHI0 = ~PHI0;

    // Reference model: command in flight, index of its post-accept cycle and
    // how many busy cycles remain, plus values captured along the way.
    bit          m_valid = 0;
    logic [15:0] m_pc, m_base, m_target, tgt;
    logic [7:0]  m_lo;
    int          m_op, m_idx, m_left;
    logic [15:0] e_addr;
    logic [7:0]  e_db;
    logic        e_busy, e_vec, e_ready, e_acc, e_pnow, e_psec;
    logic [45:0] exp_v, act_v;

    always @(negedge PHI0) begin
        if (m_valid) begin
            e_busy  = (m_left > 0);
            e_vec   = e_busy && (m_op == OP_VEC);
            e_addr  = e_vec ? m_base + 16'(m_idx) : m_pc;
            e_ready = !e_busy && !n_ready && !RES;
            e_acc   = cmd_valid && e_ready;
            e_pnow  = e_acc && (int'(cmd) == OP_PUSH);
            e_psec  = e_busy && (m_op == OP_PUSH);
            e_db    = e_pnow ? m_pc[15:8] : (e_psec ? m_pc[7:0] : 8'h00);
            exp_v = {m_pc, e_addr, e_db, e_pnow, e_psec, !e_vec, !e_vec, e_busy, e_ready};
            act_v = {PC, ADDR, DB, PCH_DB, PCL_DB, PCL_ADL, PCH_ADH, busy, cmd_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got PC=%h ADDR=%h DB=%h flags=%b required PC=%h ADDR=%h DB=%h flags=%b",
                         $time, PC, ADDR, DB, act_v[5:0], m_pc, e_addr, e_db, exp_v[5:0]);
            end
        end
        if (RES) begin
            m_valid = 1;
            m_pc = 16'h0000; m_lo = 8'h00; m_base = 16'hFFFC;
            m_op = OP_VEC; m_idx = 0; m_left = 2;
        end else if (m_valid && !n_ready) begin
            if (m_left > 0) begin
                case (m_op)
                    OP_VEC:    if (m_idx == 0) m_lo = DL; else m_pc = {DL, m_lo};
                    OP_JMP:    m_pc = {DL, m_lo};
                    OP_BRANCH: m_pc = m_target;
                    default: ;
                endcase
                m_idx++;
                m_left--;
            end else if (cmd_valid) begin
                m_op = int'(cmd);
                m_idx = 0;
                case (int'(cmd))
                    OP_INC: m_pc = m_pc + 16'd1;
                    OP_BRANCH: begin
                        tgt = m_pc + {{8{DL[7]}}, DL};
`ifdef PC_BRANCH_PAGEFIX_EN
                        if (tgt[15:8] != m_pc[15:8]) begin
                            m_target = tgt;
                            m_pc = {m_pc[15:8], tgt[7:0]};
                            m_left = 1;
                        end else m_pc = tgt;
`else
                        m_pc = tgt;
`endif
                    end
                    OP_JMP:  begin m_lo = DL; m_left = 1; end
                    OP_PUSH: m_left = 1;
                    OP_VEC:  begin m_base = vec_sel ? 16'hFFFA : 16'hFFFE; m_left = 2; end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge PHI0);
        #2;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic do_jmp(input logic [15:0] a);
        cmd_valid = 1; cmd = 3'(OP_JMP); DL = a[7:0];
        tick();
        cmd_valid = 0; cmd = 3'd0; DL = a[15:8];
        tick();
        #1 chk("jmp_setup_pc", PC, a);
    endtask

    initial begin
        RES = 1; n_ready = 0; cmd = 3'd0; vec_sel = 0; cmd_valid = 0; DL = 8'h00;
        tick();
        tick();
        chk("reset_pc", PC, 16'h0000);
        chk("reset_addr", ADDR, 16'hFFFC);
        chk("reset_busy", 16'(busy), 16'd1);
        chk("reset_ready", 16'(cmd_ready), 16'd0);
        chk("reset_db", {8'h00, DB}, 16'h0000);
        chk("reset_strobes", {12'h000, PCH_DB, PCL_DB, PCL_ADL, PCH_ADH}, 16'h0000);

        RES = 0; DL = 8'h34;
        #1 chk("rv_lo_addr", ADDR, 16'hFFFC);
        tick(); DL = 8'h12;
        #1 chk("rv_hi_addr", ADDR, 16'hFFFD);
        tick();
        #1 chk("rv_pc", PC, 16'h1234);
        chk("rv_ready", 16'(cmd_ready), 16'd1);

        do_jmp(16'h12F0);
        cmd_valid = 1; cmd = 3'(OP_BRANCH); DL = 8'h20;
        tick(); cmd_valid = 0; cmd = 3'd0;
`ifdef PC_BRANCH_PAGEFIX_EN
        #1 chk("br_fwd_partial", PC, 16'h1210);
        chk("br_fwd_fix_busy", 16'(busy), 16'd1);
        tick();
`endif
        #1 chk("br_fwd_pc", PC, 16'h1310);
        chk("br_fwd_idle", 16'(busy), 16'd0);

        do_jmp(16'h1205);
        cmd_valid = 1; cmd = 3'(OP_BRANCH); DL = 8'hF0;
        tick(); cmd_valid = 0; cmd = 3'd0;
`ifdef PC_BRANCH_PAGEFIX_EN
        #1 chk("br_back_partial", PC, 16'h12F5);
        tick();
`endif
        #1 chk("br_back_pc", PC, 16'h11F5);

        do_jmp(16'hFFFF);
        cmd_valid = 1; cmd = 3'(OP_INC);
        tick(); cmd_valid = 0; cmd = 3'd0;
        #1 chk("inc_wrap", PC, 16'h0000);

        do_jmp(16'hABCD);
        cmd_valid = 1; cmd = 3'(OP_PUSH);
        #1 chk("push_hi_db", {8'h00, DB}, 16'h00AB);
        chk("push_hi_strobe", {14'h0, PCH_DB, PCL_DB}, 16'h0002);
        tick(); cmd_valid = 0; cmd = 3'd0;
        #1 chk("push_lo_db", {8'h00, DB}, 16'h00CD);
        chk("push_lo_strobe", {14'h0, PCH_DB, PCL_DB}, 16'h0001);
        chk("push_lo_ready", 16'(cmd_ready), 16'd0);
        chk("push_pc", PC, 16'hABCD);
        tick();
        #1 chk("push_done_db", {8'h00, DB}, 16'h0000);
        chk("push_done_ready", 16'(cmd_ready), 16'd1);

        cmd_valid = 1; cmd = 3'(OP_JMP); DL = 8'h55;
        tick(); cmd_valid = 0; cmd = 3'd0;
        n_ready = 1;
        for (int i = 0; i < 3; i++) begin
            DL = 8'(8'h11 + i);
            #1 chk("stall_busy", 16'(busy), 16'd1);
            chk("stall_pc", PC, 16'hABCD);
            chk("stall_ready", 16'(cmd_ready), 16'd0);
            tick();
        end
        n_ready = 0; DL = 8'h80;
        tick();
        #1 chk("jmp_after_stall", PC, 16'h8055);

        cmd_valid = 1; cmd = 3'(OP_VEC); vec_sel = 1;
        tick(); cmd_valid = 0; cmd = 3'd0; DL = 8'h77;
        #1 chk("nmi_lo_addr", ADDR, 16'hFFFA);
        chk("nmi_lo_adl", 16'(PCL_ADL), 16'd0);
        tick(); DL = 8'h66;
        #1 chk("nmi_hi_addr", ADDR, 16'hFFFB);
        RES = 1;
        tick();
        #1 chk("abort_pc", PC, 16'h0000);
        chk("abort_addr", ADDR, 16'hFFFC);
        chk("abort_busy", 16'(busy), 16'd1);
        RES = 0;

        for (int c = 0; c < 3000; c++) begin
            RES       = ($urandom_range(0, 63) == 0);
            n_ready   = ($urandom_range(0, 5) == 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd       = 3'($urandom_range(0, 5));
            vec_sel   = 1'($urandom_range(0, 1));
            DL        = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
